packet_sort_stream: RTL
=======================

# packet_sort_stream

Streaming packet sorter: accepts one packet of up to 2**AWIDTH words on the sop/eop/val input bus, keeps it sorted on arrival (insertion into a register array), then replays it in ascending or descending order on a ready-backpressured output bus. It is the parametrised successor of the single-packet sorter, and adds:
- per-packet sort direction;
- signed or unsigned compare;
- output backpressure;
- overflow and abort detection.

## Interface
- DWIDTH, 8: data word width.
- AWIDTH, 3: max packet length MAX_LEN = 2**AWIDTH words.
- SIGNED_CMP, 0: 1 = compare words as two's complement.

- clk_i  in  1  single clock, rising edge.
- arst_n_i  in  1  reset, asynchronous assert, active-low.
- data_i  in  DWIDTH  input word.
- sop_i  in  1  first word of packet.
- eop_i  in  1  last word of packet.
- val_i  in  1  qualifies data_i/sop_i/eop_i/desc_i.
- desc_i  in  1  sort direction (1 = descending), sampled on the accepted sop word.
- data_o  out  DWIDTH  output word.
- sop_o  out  1  first output word.
- eop_o  out  1  last output word.
- val_o  out  1  qualifies data_o/sop_o/eop_o.
- ready_i  in  1  sink accepts the output word when val_o & ready_i.
- busy_o  out  1  input ignored while high.
- err_o  out  1  one-cycle pulse on a protocol error.

## Operation
- States: IDLE, FILL, DRAIN.
- Registers: array arr[0..MAX_LEN-1], count (AWIDTH+1 bits), rd_idx (AWIDTH bits), dir, ovf.
- IDLE, on val_i & sop_i:
  - Clear the array, write the word to arr[0], set count=1 and latch dir=desc_i.
  - If eop_i is also high, go to DRAIN; otherwise go to FILL.
- IDLE, on val_i & !sop_i: drop the word and pulse err_o.
- FILL, on val_i:
  - If sop_i: pulse err_o, discard the old contents and restart as in IDLE.
  - Else if count < MAX_LEN: insert the word.
  - Else: drop the word, pulse err_o, set ovf.
  - eop_i (with a non-sop word) moves to DRAIN whether or not the word was stored.
- Insertion:
  - pos = number of stored entries e with e <= new (ascending) or e >= new (descending). Equal keys keep arrival order (stable).
  - Slots i < pos are unchanged; slot pos gets the new word; slots pos < i <= count get arr[i-1]. count increments.
- DRAIN:
  - data_o=arr[rd_idx], val_o=1, sop_o=(rd_idx==0), eop_o=(rd_idx==count-1).
  - On val_o & ready_i: rd_idx++. After the eop handshake, go to IDLE and clear rd_idx and ovf.
- busy_o = (state==DRAIN); val_i is ignored in DRAIN.
- Comparison is unsigned unless SIGNED_CMP=1. Width rule: count is AWIDTH+1 bits so MAX_LEN is representable.

## Timing
- All outputs are registered-state driven; there is no combinational path from data_i/val_i/sop_i/eop_i to any output. ready_i reaches only the internal state.
- Reset (any time, including mid-FILL or mid-DRAIN): state=IDLE, count=0, rd_idx=0, ovf=0.
  - data_o, sop_o, eop_o, val_o, busy_o and err_o are all 0.
  - Array contents are don't-care.
- Latency: eop accepted at edge T gives val_o=1, sop_o=1 and the first sorted word in cycle T+1.
- Output holds data and flags stable while val_o & !ready_i.
- Throughput: one input word per cycle in FILL. One output word per cycle in DRAIN with ready_i held high, so a packet of N words drains in N cycles.
- Single-word packet: sop_o and eop_o are high in the same cycle.
- err_o is high exactly for the cycle after the offending edge.
- After the final output handshake at edge E, busy_o=0 in cycle E+1 and an input sop is accepted at edge E+1.

## Structure
- Shared package packet_sort_pkg holds:
  - state enum state_t {IDLE, FILL, DRAIN};
  - MAX_LEN as a function of AWIDTH.
- Sub-module sort_insert_array (DWIDTH, AWIDTH, SIGNED_CMP):
  - Holds the register array and count.
  - Inputs: clear, ins_en, ins_data, dir, rd_idx. Outputs: rd_data, count, full.
- Top level holds the FSM, error logic and output flags.

## Test plan
- Ascending, unsigned, MAX_LEN=8: input 5,3,7,1 (sop on 5, eop on 1), ready_i=1 -> output 1,3,5,7 in 4 consecutive cycles, sop_o on 1, eop_o on 7, first val_o one cycle after eop.
- Descending, SIGNED_CMP=1, DWIDTH=8: 0x80,0x7F,0x00 -> output 0x7F,0x00,0x80. Stability check with tagged duplicates 2a,2b -> emitted in order 2a,2b.
- Overflow: 10 words into MAX_LEN=8 -> two err_o pulses, the 8 smallest of the first 8 words are emitted, the last two words are dropped.
- Backpressure: toggle ready_i randomly -> exactly count handshakes, data_o stable while stalled, busy_o high until the eop handshake.
- Protocol errors:
  - sop mid-FILL -> err_o pulse; only the new packet is emitted.
  - val_i without sop in IDLE -> err_o pulse, nothing emitted.
  - Single-word packet -> sop_o=eop_o=1 in one cycle.
- Reset: assert arst_n_i mid-DRAIN -> all outputs are 0 immediately (asynchronous). After release, a new packet 2,1 sorts to 1,2 correctly.

Source files
------------

// File: rtl/packet_sort_pkg.sv
// Shared definitions for the streaming packet sorter.
//   state_t : controller states (IDLE -> FILL -> DRAIN -> IDLE)
//   max_len : packet capacity in words for a given address width
package packet_sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned max_len(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/packet_sort_stream_insert_array.sv
// Sorted register array with single-word insertion.
// Ports:
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   clear           : empty the array (combined with ins_en: store ins_data at slot 0)
//   ins_en          : insert ins_data at its ordered position (ignored when full)
//   ins_data        : word to insert
//   dir             : 0 = ascending, 1 = descending order
//   rd_idx          : read address
//   rd_data         : arr[rd_idx]
//   count           : number of stored words (AWIDTH+1 bits, MAX_LEN representable)
//   full            : count == MAX_LEN
module sort_insert_array
  import packet_sort_pkg::*;
#(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned AWIDTH     = 3,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              clear,
  input  logic              ins_en,
  input  logic [DWIDTH-1:0] ins_data,
  input  logic              dir,
  input  logic [AWIDTH-1:0] rd_idx,
  output logic [DWIDTH-1:0] rd_data,
  output logic [AWIDTH:0]   count,
  output logic              full
);

  localparam int unsigned     MAX_LEN = max_len(AWIDTH);
  localparam logic [AWIDTH:0] MAX_CNT = (AWIDTH+1)'(MAX_LEN);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [DWIDTH-1:0] KEY_FLIP = (SIGNED_CMP != 0) ?
                                           {1'b1, {(DWIDTH-1){1'b0}}} : {DWIDTH{1'b0}};

  logic [DWIDTH-1:0] arr_r     [MAX_LEN];
  logic [DWIDTH-1:0] ins_arr_s [MAX_LEN];
  logic [MAX_LEN-1:0] keep_s;
  logic [AWIDTH:0]   count_r;
  logic              full_s;

  // True when stored word e stays ahead of new word n; ties keep arrival order.
  function automatic logic stays_before(input logic [DWIDTH-1:0] e,
                                        input logic [DWIDTH-1:0] n,
                                        input logic              d);
    logic [DWIDTH-1:0] ek;
    logic [DWIDTH-1:0] nk;
    ek = e ^ KEY_FLIP;
    nk = n ^ KEY_FLIP;
    if (d) begin
      return ek >= nk;
    end else begin
      return ek <= nk;
    end
  endfunction

  assign full_s  = (count_r == MAX_CNT);
  assign full    = full_s;
  assign count   = count_r;
  assign rd_data = arr_r[rd_idx];

  // Build the post-insertion array. keep_s is a prefix of ones because the
  // array is already sorted, so the first zero is the insertion slot.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      keep_s[i] = ((AWIDTH+1)'(i) < count_r) && stays_before(arr_r[i], ins_data, dir);
    end
    if (keep_s[0]) begin
      ins_arr_s[0] = arr_r[0];
    end else begin
      ins_arr_s[0] = ins_data;
    end
    for (int i = 1; i < MAX_LEN; i++) begin
      if (keep_s[i]) begin
        ins_arr_s[i] = arr_r[i];
      end else if (keep_s[i-1]) begin
        ins_arr_s[i] = ins_data;
      end else begin
        ins_arr_s[i] = arr_r[i-1];
      end
    end
  end

  // Array and count storage: clear/restart, ordered insert, or hold.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      count_r <= {(AWIDTH+1){1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
        arr_r[i] <= {DWIDTH{1'b0}};
      end
    end else if (clear) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        arr_r[i] <= {DWIDTH{1'b0}};
      end
      if (ins_en) begin
        arr_r[0] <= ins_data;
        count_r  <= CNT_ONE;
      end else begin
        arr_r[0] <= {DWIDTH{1'b0}};
        count_r  <= {(AWIDTH+1){1'b0}};
      end
    end else if (ins_en && !full_s) begin
      arr_r   <= ins_arr_s;
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/packet_sort_stream.sv
// Streaming packet sorter: collects one packet (sop/eop/val) into a sorted
// array, then replays it in ascending or descending order with backpressure.
// Ports:
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   data_i/sop_i/eop_i/val_i : input packet bus; desc_i sampled on the sop word
//   data_o/sop_o/eop_o/val_o : output packet bus, advanced on val_o & ready_i
//   ready_i                  : sink ready
//   busy_o                   : draining, input is ignored
//   err_o                    : one-cycle pulse after a protocol error
module packet_sort_stream
  import packet_sort_pkg::*;
#(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned AWIDTH     = 3,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  input  logic              desc_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] IDX_ONE = AWIDTH'(1);

  state_t              state_r, state_s;
  logic [AWIDTH-1:0]   rd_idx_r, rd_idx_s;
  logic                dir_r, dir_s;
  logic                ovf_r, ovf_s;
  logic                err_r, err_s;
  logic                clear_s;
  logic                ins_en_s;
  logic [DWIDTH-1:0]   rd_data_s;
  logic [AWIDTH:0]     count_s;
  logic                full_s;
  logic                drain_s;
  logic                last_s;

  sort_insert_array #(
    .DWIDTH     (DWIDTH),
    .AWIDTH     (AWIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_array (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clear    (clear_s),
    .ins_en   (ins_en_s),
    .ins_data (data_i),
    .dir      (dir_r),
    .rd_idx   (rd_idx_r),
    .rd_data  (rd_data_s),
    .count    (count_s),
    .full     (full_s)
  );

  assign drain_s = (state_r == DRAIN);
  assign last_s  = ({1'b0, rd_idx_r} == (count_s - CNT_ONE));

  // Next-state and control decode for the IDLE/FILL/DRAIN controller.
  always_comb begin
    state_s  = state_r;
    rd_idx_s = rd_idx_r;
    dir_s    = dir_r;
    ovf_s    = ovf_r;
    err_s    = 1'b0;
    clear_s  = 1'b0;
    ins_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (val_i && sop_i) begin
          clear_s  = 1'b1;
          ins_en_s = 1'b1;
          dir_s    = desc_i;
          ovf_s    = 1'b0;
          state_s  = eop_i ? DRAIN : FILL;
        end else if (val_i) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      FILL: begin
        if (val_i && sop_i) begin
          // A new sop abandons the packet in progress and restarts.
          err_s    = 1'b1;
          clear_s  = 1'b1;
          ins_en_s = 1'b1;
          dir_s    = desc_i;
          ovf_s    = 1'b0;
          state_s  = eop_i ? DRAIN : FILL;
        end else if (val_i) begin
          if (!full_s && !ovf_r) begin
            ins_en_s = 1'b1;
          end else begin
            err_s = 1'b1;
            ovf_s = 1'b1;
          end
          state_s = eop_i ? DRAIN : FILL;
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        if (ready_i && last_s) begin
          state_s  = IDLE;
          rd_idx_s = {AWIDTH{1'b0}};
          ovf_s    = 1'b0;
        end else if (ready_i) begin
          rd_idx_s = rd_idx_r + IDX_ONE;
        end else begin
          rd_idx_s = rd_idx_r;
        end
      end
      default: begin
        state_s  = IDLE;
        rd_idx_s = {AWIDTH{1'b0}};
        ovf_s    = 1'b0;
      end
    endcase
  end

  // Controller state, read pointer, direction, overflow and error registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r  <= IDLE;
      rd_idx_r <= {AWIDTH{1'b0}};
      dir_r    <= 1'b0;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      rd_idx_r <= rd_idx_s;
      dir_r    <= dir_s;
      ovf_r    <= ovf_s;
      err_r    <= err_s;
    end
  end

  // Outputs decode only registered state; data is forced to zero outside DRAIN.
  assign val_o  = drain_s;
  assign busy_o = drain_s;
  assign data_o = drain_s ? rd_data_s : {DWIDTH{1'b0}};
  assign sop_o  = drain_s && (rd_idx_r == {AWIDTH{1'b0}});
  assign eop_o  = drain_s && last_s;
  assign err_o  = err_r;

endmodule
